// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_if
//  Purpose  : Request/response bundle between the execute stage and alu_seq.
//             Request side: in_valid/in_ready handshake with sel, arg1, arg2.
//             Response side: out_valid/out_ready handshake with result and
//             carry/zero flags.
//  Modports : master - pipeline side (drives requests, takes results)
//             slave  - ALU side (takes requests, drives results)
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] arg1;
    logic [WIDTH-1:0] arg2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero_out;

    modport master (
        output in_valid, sel, arg1, arg2, out_ready,
        input  in_ready, out_valid, result, carry_out, zero_out
    );

    modport slave (
        input  in_valid, sel, arg1, arg2, out_ready,
        output in_ready, out_valid, result, carry_out, zero_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Handshaked, registered ALU for the execute stage. ADD, NAND
//             and SUB complete in one cycle; MUL (sel=11) is an iterative
//             shift-add taking WIDTH cycles when ALU_MUL_EN is defined,
//             otherwise sel=11 behaves as ADD and no multiply state exists.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - alu_if.slave (request and response handshakes)
//  Macros   : ALU_MUL_EN - enables the iterative multiplier
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [WIDTH:0] c_one_ext = {{WIDTH{1'b0}}, 1'b1};

    // Output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_q,     carry_d;
    logic             zero_q,      zero_d;

    // Value being loaded into the output registers this cycle
    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic             ld_carry;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             accept;
    logic             drain;
    logic             in_ready;

    state_t           state_q;

`ifdef ALU_MUL_EN
    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q,  mplr_d;
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2*WIDTH-1:0] acc_sum;
`else
    // Without the multiplier the FSM never leaves IDLE.
    assign state_q = ST_IDLE;
`endif

    assign add_sum = {1'b0, bus.arg1} + {1'b0, bus.arg2};
    assign sub_sum = {1'b0, bus.arg1} + {1'b0, ~bus.arg2} + c_one_ext;

    // No path from in_valid: ready depends only on state and output slot.
    assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign drain    = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ld          = 1'b0;
        ld_res      = '0;
        ld_carry    = 1'b0;
`ifdef ALU_MUL_EN
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_sum     = '0;
`endif

        if (drain) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (bus.sel)
                2'b01: begin
                    ld       = 1'b1;
                    ld_res   = ~(bus.arg1 & bus.arg2);
                    ld_carry = 1'b0;
                end
                2'b10: begin
                    ld       = 1'b1;
                    ld_res   = sub_sum[WIDTH-1:0];
                    ld_carry = sub_sum[WIDTH];
                end
`ifdef ALU_MUL_EN
                2'b11: begin
                    // Output slot is empty (or drained on this edge), so it
                    // stays empty for the whole multiply.
                    mcand_d     = {{WIDTH{1'b0}}, bus.arg1};
                    mplr_d      = bus.arg2;
                    acc_d       = '0;
                    cnt_d       = c_cnt_init;
                    state_d     = ST_BUSY;
                    out_valid_d = 1'b0;
                end
`endif
                default: begin
                    ld       = 1'b1;
                    ld_res   = add_sum[WIDTH-1:0];
                    ld_carry = add_sum[WIDTH];
                end
            endcase
        end

`ifdef ALU_MUL_EN
        if (state_q == ST_BUSY) begin
            acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - c_cnt_one;
            if (cnt_q == c_cnt_one) begin
                ld       = 1'b1;
                ld_res   = acc_sum[WIDTH-1:0];
                ld_carry = |acc_sum[2*WIDTH-1:WIDTH];
                state_d  = ST_IDLE;
            end
        end
`endif

        if (ld) begin
            result_d    = ld_res;
            carry_d     = ld_carry;
            zero_d      = (ld_res == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_out  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq (WIDTH = 16).
//             Multiply checks are built when ALU_MUL_EN is defined; otherwise
//             sel=11 is checked as ADD.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_if #(.WIDTH(16)) bus ();

    alu_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one single-cycle op at a negedge, check it is accepted and that
    // the registered result is visible right after the next rising edge.
    task automatic op_check(input string tag, input logic [1:0] s,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] er, input logic ec, input logic ez);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.arg1     = a;
        bus.arg2     = b;
        #1;
        check({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".result"},    {16'd0, bus.result},    {16'd0, er});
        check({tag, ".carry"},     {31'd0, bus.carry_out}, {31'd0, ec});
        check({tag, ".zero"},      {31'd0, bus.zero_out},  {31'd0, ez});
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] er, input logic ec, input logic ez);
        int bad_busy;
        bad_busy = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel      = 2'b11;
        bus.arg1     = a;
        bus.arg2     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Edges k+1 .. k+15: still busy, nothing valid, not ready.
        for (int i = 0; i < 16; i++) begin
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad_busy++;
            if (i < 15) begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, ".busy_cycles_bad"}, bad_busy, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".result"},    {16'd0, bus.result},    {16'd0, er});
        check({tag, ".carry"},     {31'd0, bus.carry_out}, {31'd0, ec});
        check({tag, ".zero"},      {31'd0, bus.zero_out},  {31'd0, ez});
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sel       = 2'b00;
        bus.arg1      = '0;
        bus.arg2      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.result",    {16'd0, bus.result},    32'd0);
        check("rst.carry",     {31'd0, bus.carry_out}, 32'd0);
        check("rst.zero",      {31'd0, bus.zero_out},  32'd0);
        check("rst.in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle.in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single-cycle ops, back to back with out_ready high
        op_check("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
        op_check("nand",     2'b01, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0);
        op_check("sub_7_5",  2'b10, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0);
        op_check("sub_5_7",  2'b10, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        op_check("sub_eq",   2'b10, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1);

        // Drain without a new load: valid drops, data keeps its last value
        @(posedge clk);
        #1;
        check("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("drain.result",    {16'd0, bus.result},    32'd0);
        check("drain.zero",      {31'd0, bus.zero_out},  32'd1);

        // Backpressure: hold first result 5 cycles, then drain+accept together
        op_check("bp_first", 2'b00, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'b00;
        bus.arg1      = 16'h0100;
        bus.arg2      = 16'h0001;
        #1;
        check("bp.in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp.hold_in_ready", {31'd0, bus.in_ready},  32'd0);
            check("bp.hold_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp.hold_result",   {16'd0, bus.result},    32'h0030);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp.second_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("bp.second_result", {16'd0, bus.result},    32'h0101);
        @(posedge clk);
        #1;
        check("bp.no_duplicate",  {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_MUL_EN
        mul_check("mul_3x5",     16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
        mul_check("mul_ovf",     16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
        mul_check("mul_ffxff",   16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 1'b0);

        // Reset in the middle of a multiply: outputs clear at once, no pulse
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel      = 2'b11;
        bus.arg1     = 16'h0003;
        bus.arg2     = 16'h0007;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("mrst.pre_result", {16'd0, bus.result}, 32'hFE01);
        rst = 1'b1;
        #1;
        check("mrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst.result",    {16'd0, bus.result},    32'd0);
        check("mrst.carry",     {31'd0, bus.carry_out}, 32'd0);
        check("mrst.zero",      {31'd0, bus.zero_out},  32'd0);
        check("mrst.in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (bus.out_valid !== 1'b0) pulses++;
            end
            check("mrst.no_pulse", pulses, 32'd0);
        end
        check("mrst.idle_ready", {31'd0, bus.in_ready}, 32'd1);
        op_check("post_rst_add", 2'b00, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);
`else
        op_check("sel11_add",    2'b11, 16'h0004, 16'h0006, 16'h000A, 1'b0, 1'b0);
        op_check("sel11_carry",  2'b11, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
        op_check("hold_val",     2'b00, 16'h0020, 16'h0001, 16'h0021, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst.result",    {16'd0, bus.result},    32'd0);
        check("arst.in_ready",  {31'd0, bus.in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        op_check("post_rst_add", 2'b00, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Time limit so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
